io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Downstream consumer of the Reduceron core's IO write port (iowrite/ioaddr/iowd) and its finish strobe.
- Captures byte writes to a fixed IO address into a small FIFO and serialises them as 8N1 UART frames on txd.
- Reports drop-on-full overflow and a drained flag (finish seen and all output sent).
- Replaces simulation-only $display of IO writes on the FPGA build.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_LOG2, 4, log2 of FIFO depth (default depth 16).
- UART_ADDR, 13'd0, ioaddr value that selects the UART data register.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- iowrite  input  1  IO write strobe from core, single-cycle per write.
- ioaddr  input  13  IO write address.
- iowd  input  13  IO write data; bits [7:0] form the byte, [12:8] are ignored.
- finish  input  1  core finished; level or pulse.
- txd  output  1  UART serial out, idle high.
- busy  output  1  FIFO non-empty or frame in progress.
- overflow  output  1  sticky; a write was dropped.
- drained  output  1  finish seen and busy low.

Behaviour:
- Reset (synchronous, active-high) sets txd=1, busy=0, overflow=0, drained=0, FIFO empty, FSM IDLE, bit counter and divider 0, finish_seen=0. Reset mid-frame aborts the frame: txd=1 on the next cycle and queued bytes are discarded.
- Accept condition: iowrite && ioaddr==UART_ADDR. Other addresses are ignored with no flag.
- Push rule:
  - Push iowd[7:0] if count<DEPTH, or if the FSM pops in the same cycle.
  - Otherwise drop the byte; overflow=1 from the next cycle until reset.
- FIFO: count width FIFO_LOG2+1; pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
- Latency: a write accepted at edge N makes the FIFO non-empty after N. The FSM pops at edge N+1 and txd=0 (start bit) from N+1 onward.
- FSM states:
  - IDLE: txd=1. If FIFO non-empty: pop into the shift register, reload the divider, go to START.
  - START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Each bit lasts CLK_DIV cycles; after bit 7 go to STOP.
  - STOP: txd=1 for CLK_DIV cycles, then IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle when the FIFO is non-empty, so the frame period is 10*CLK_DIV+1 cycles.
- Divider counts CLK_DIV-1 down to 0; the state/bit advances when it reaches 0.
- busy = (state!=IDLE) || (count!=0).
- finish_seen is set when finish=1 and is sticky. drained = finish_seen && !busy, registered with 1-cycle lag.
  - finish with an empty FIFO: drained=1 two cycles later.
  - A write arriving after drained=1 clears drained while it is transmitted.

Optional Feature:
- Macro: IO_UART_CRLF_EN.
- Defined: when the popped byte is 8'h0A, the FSM first sends an 8'h0D frame, then 8'h0A, with no IDLE cycle between them. FIFO occupancy is unchanged (one entry). busy stays high across both frames.
- Undefined: bytes are sent verbatim.

Decomposition:
- Package io_uart_pkg: FSM state enum (IDLE, START, DATA, STOP), FRAME_BITS=10, CHAR_CR=8'h0D, CHAR_LF=8'h0A.
- Sub-module io_uart_fifo: synchronous FIFO parameterised by width 8 and FIFO_LOG2.
  - Ports: clock, reset, push, din, pop, dout, count, full, empty.
  - Push-when-full-with-pop is allowed.

Test Plan (CLK_DIV=4, FIFO_LOG2=4):
- Reset, then idle 50 cycles -> txd=1, busy=0, overflow=0, drained=0 throughout.
- Write ioaddr=0, iowd=13'h1041 at edge 10 -> txd low from edge 11; bits 0,1,0,0,0,0,0,1,0,1, each 4 cycles (byte 0x41); busy falls at edge 51.
- Write ioaddr=5, iowd=0x55 -> txd stays 1, busy stays 0, overflow stays 0.
- 18 back-to-back writes of 0x00..0x11 to addr 0 -> writes 0..16 accepted, write 17 dropped; overflow=1 the cycle after; txd emits 0x00..0x10 in order, 17 frames.
- Write 0x30, assert finish 1 cycle later -> drained stays 0 until the stop bit ends, rises 1 cycle after busy falls.
- Reset asserted mid-DATA with 3 bytes queued -> next cycle txd=1, busy=0; no further frames.
- With IO_UART_CRLF_EN, write 0x0A -> frames 0x0D then 0x0A, 80 cycles contiguous. Without the macro -> single 0x0A frame.

Source files
------------

// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_pkg
//  Description : Shared FSM state encoding and character constants for the
//                IO-port UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

   // Transmit FSM state encoding (2-bit, legacy-compatible constants)
   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   // One 8N1 frame: start + 8 data + stop
   localparam int FRAME_BITS = 10;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage : io_uart_pkg
`default_nettype wire

// File: rtl/io_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_fifo
//  Description : Synchronous FIFO, depth 2**FIFO_LOG2, with combinational
//                read data. A push while full is accepted when a pop happens
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_fifo #(
   parameter int WIDTH     = 8,
   parameter int FIFO_LOG2 = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     din,
   input  logic                 pop,
   output logic [WIDTH-1:0]     dout,
   output logic [FIFO_LOG2:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 1 << FIFO_LOG2;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [FIFO_LOG2:0]   cnt;
   logic                 do_push;
   logic                 do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Occupancy never exceeds DEPTH, so the count MSB alone means "full"
   assign full  = cnt[FIFO_LOG2];
   assign empty = (cnt == '0);
   assign count = cnt;
   assign dout  = mem[rd_ptr];

   // Storage array; contents are don't-care while the pointers say empty
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally modulo DEPTH; count tracks net push/pop
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : io_uart_fifo
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_tx
//  Description : Captures core IO writes to UART_ADDR into a FIFO and sends
//                them as 8N1 frames on txd. Sticky overflow on dropped
//                writes; drained once finish was seen and all output is sent.
//  Options     : IO_UART_CRLF_EN - when defined, a popped LF (0x0A) is sent
//                as CR then LF back to back.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_tx
   import io_uart_pkg::*;
#(
   parameter int          CLK_DIV   = 434,
   parameter int          FIFO_LOG2 = 4,
   parameter logic [12:0] UART_ADDR = 13'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iowrite,
   input  logic [12:0] ioaddr,
   input  logic [12:0] iowd,
   input  logic        finish,
   output logic        txd,
   output logic        busy,
   output logic        overflow,
   output logic        drained
);

   localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

   uart_state_t          state;
   logic [15:0]          div;
   logic [2:0]           bit_idx;
   logic [7:0]           shift;
   logic                 txd_q;
   logic                 finish_seen;

   logic                 accept;
   logic                 fifo_pop;
   logic [7:0]           fifo_dout;
   logic [FIFO_LOG2:0]   fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 unused_iowd_hi;

`ifdef IO_UART_CRLF_EN
   logic                 lf_pending;
`endif

   assign accept         = iowrite && (ioaddr == UART_ADDR);
   assign unused_iowd_hi = ^iowd[12:8];

   // The FSM takes a byte only from IDLE, which lasts one cycle when data waits
   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

   assign busy = (state != ST_IDLE) || (fifo_count != '0);
   assign txd  = txd_q;

   io_uart_fifo #(
      .WIDTH     (8),
      .FIFO_LOG2 (FIFO_LOG2)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .din   (iowd[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Frame sequencer: txd is registered alongside each state change
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         div     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd_q   <= 1'b1;
`ifdef IO_UART_CRLF_EN
         lf_pending <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               txd_q <= 1'b1;
               if (!fifo_empty) begin
                  state <= ST_START;
                  div   <= DIV_MAX;
                  txd_q <= 1'b0;
`ifdef IO_UART_CRLF_EN
                  // LF occupies one FIFO entry but goes out as CR then LF
                  if (fifo_dout == CHAR_LF) begin
                     shift      <= CHAR_CR;
                     lf_pending <= 1'b1;
                  end else begin
                     shift <= fifo_dout;
                  end
`else
                  shift <= fifo_dout;
`endif
               end
            end

            ST_START: begin
               if (div == '0) begin
                  state   <= ST_DATA;
                  div     <= DIV_MAX;
                  bit_idx <= '0;
                  txd_q   <= shift[0];
               end else begin
                  div <= div - 1'b1;
               end
            end

            ST_DATA: begin
               if (div == '0) begin
                  div <= DIV_MAX;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     txd_q <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= {1'b0, shift[7:1]};
                     txd_q   <= shift[1];
                  end
               end else begin
                  div <= div - 1'b1;
               end
            end

            ST_STOP: begin
               if (div == '0) begin
`ifdef IO_UART_CRLF_EN
                  if (lf_pending) begin
                     // Chain the LF frame directly, no IDLE cycle in between
                     state      <= ST_START;
                     div        <= DIV_MAX;
                     shift      <= CHAR_LF;
                     lf_pending <= 1'b0;
                     txd_q      <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
`else
                  state <= ST_IDLE;
`endif
               end else begin
                  div <= div - 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               txd_q <= 1'b1;
            end
         endcase
      end
   end

   // Sticky status: dropped-write flag, finish capture and drained report
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow    <= 1'b0;
         finish_seen <= 1'b0;
         drained     <= 1'b0;
      end else begin
         if (accept && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end
         if (finish) begin
            finish_seen <= 1'b1;
         end
         drained <= finish_seen && !busy;
      end
   end

endmodule : io_uart_tx
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart_tx
//  Description : Self-checking bench for io_uart_tx. A frame-level model
//                (byte queue + cycles-remaining-in-frame) predicts txd, busy,
//                overflow and drained every cycle. Directed scenarios are
//                followed by a randomized phase.
//  Options     : IO_UART_CRLF_EN - model follows the CR/LF expansion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

   localparam int          CLK_DIV   = 4;
   localparam int          FIFO_LOG2 = 4;
   localparam int          DEPTH     = 1 << FIFO_LOG2;
   localparam int          FRAME_CYC = 10 * CLK_DIV;
   localparam logic [12:0] ADDR      = 13'd0;

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic        iowrite = 1'b0;
   logic [12:0] ioaddr  = '0;
   logic [12:0] iowd    = '0;
   logic        finish  = 1'b0;
   logic        txd;
   logic        busy;
   logic        overflow;
   logic        drained;

   io_uart_tx #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_LOG2 (FIFO_LOG2),
      .UART_ADDR (ADDR)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iowrite  (iowrite),
      .ioaddr   (ioaddr),
      .iowd     (iowd),
      .finish   (finish),
      .txd      (txd),
      .busy     (busy),
      .overflow (overflow),
      .drained  (drained)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queued bytes, byte on the line, cycles left in frame
   logic [7:0] mq[$];
   int         rem     = 0;
   logic [7:0] cur     = '0;
   bit         lf_pend = 1'b0;
   bit         m_ovf   = 1'b0;
   bit         m_fs    = 1'b0;
   bit         m_dr    = 1'b0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic exp_txd();
      logic [9:0] frame;
      int         idx;
      if (rem == 0) return 1'b1;
      frame = {1'b1, cur, 1'b0};
      idx   = (FRAME_CYC - rem) / CLK_DIV;
      return frame[idx];
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step(input logic wr, input logic [12:0] a, input logic [12:0] d,
                             input logic fin, input logic rst);
      bit old_busy;
      bit old_fs;
      if (rst) begin
         mq.delete();
         rem     = 0;
         lf_pend = 1'b0;
         m_ovf   = 1'b0;
         m_fs    = 1'b0;
         m_dr    = 1'b0;
         return;
      end
      old_busy = (rem > 0) || (mq.size() > 0);
      old_fs   = m_fs;
      if (rem > 0) begin
         if (rem == 1 && lf_pend) begin
            rem     = FRAME_CYC;
            cur     = 8'h0A;
            lf_pend = 1'b0;
         end else begin
            rem--;
         end
      end else if (mq.size() > 0) begin
         cur = mq.pop_front();
         rem = FRAME_CYC;
`ifdef IO_UART_CRLF_EN
         if (cur == 8'h0A) begin
            cur     = 8'h0D;
            lf_pend = 1'b1;
         end
`endif
      end
      // A pop in this same cycle has already freed its slot
      if (wr && a == ADDR) begin
         if (mq.size() < DEPTH) mq.push_back(d[7:0]);
         else                   m_ovf = 1'b1;
      end
      if (fin) m_fs = 1'b1;
      m_dr = old_fs && !old_busy;
   endtask

   task automatic cycle(input logic wr, input logic [12:0] a, input logic [12:0] d,
                        input logic fin, input logic rst);
      iowrite = wr;
      ioaddr  = a;
      iowd    = d;
      finish  = fin;
      reset   = rst;
      @(posedge clock);
      model_step(wr, a, d, fin, rst);
      #1;
      check_value("txd",      {31'd0, txd},      {31'd0, exp_txd()});
      check_value("busy",     {31'd0, busy},     {31'd0, ((rem > 0) || (mq.size() > 0))});
      check_value("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check_value("drained",  {31'd0, drained},  {31'd0, m_dr});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 13'd0, 13'd0, 1'b0, 1'b0);
   endtask

   task automatic write(input logic [12:0] a, input logic [12:0] d);
      cycle(1'b1, a, d, 1'b0, 1'b0);
   endtask

   initial begin
      logic        wr;
      logic [12:0] a;
      logic [12:0] d;
      logic        fin;
      logic        rst;

      // Reset, then quiet line
      repeat (3) cycle(1'b0, 13'd0, 13'd0, 1'b0, 1'b1);
      idle(50);

      // Single byte 0x41 with junk in the upper data bits
      write(ADDR, 13'h1041);
      idle(45);

      // Write to a different address is ignored
      write(13'd5, 13'h055);
      idle(20);

      // 18 back-to-back writes: last one overflows the FIFO
      for (int k = 0; k < 18; k++) write(ADDR, 13'(k));
      idle(17 * (FRAME_CYC + 1) + 10);

      // Drained after finish once the last frame completes
      write(ADDR, 13'h030);
      cycle(1'b0, 13'd0, 13'd0, 1'b1, 1'b0);
      idle(50);

      // Reset mid-DATA with bytes still queued
      cycle(1'b0, 13'd0, 13'd0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) write(ADDR, 13'(8'hA0 + k));
      idle(12);
      cycle(1'b0, 13'd0, 13'd0, 1'b0, 1'b1);
      idle(60);

      // Line feed: CR+LF with the option, verbatim otherwise
      write(ADDR, 13'h00A);
      idle(2 * FRAME_CYC + 10);

      // Randomized traffic with occasional finish and reset
      for (int k = 0; k < 3000; k++) begin
         wr  = ($urandom_range(0, 5) == 0);
         a   = ($urandom_range(0, 3) != 0) ? ADDR : 13'($urandom_range(1, 8191));
         d   = ($urandom_range(0, 7) == 0) ? 13'h00A : 13'($urandom);
         fin = ($urandom_range(0, 299) == 0);
         rst = ($urandom_range(0, 799) == 0);
         cycle(wr, a, d, fin, rst);
      end
      idle(DEPTH * (2 * FRAME_CYC + 1) + 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_io_uart_tx
`default_nettype wire
